// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 host-side blocks.
// Imported by the host transmitter and its line synchronizers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_t;

    // Start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between system logic and the PS/2 host transmitter.
// master = requester (system logic), slave = transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_error
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for an asynchronous PS/2 pin plus a registered
// falling-edge flag that fires one cycle after the synchronized level drops.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic fall_r;

    // Synchronizer chain and edge flag; an idle PS/2 line floats high
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
            fall_r <= 1'b0;
        end else begin
            meta_r <= pin;
            sync_r <= meta_r;
            prev_r <= sync_r;
            fall_r <= prev_r & ~sync_r;
        end
    end

    assign level = sync_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte out on device clock falling edges and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clock,
    input  logic         reset,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int CNT_MAX = max3(INHIBIT_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = ($clog2(CNT_MAX) < 2) ? 2 : $clog2(CNT_MAX);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO     = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t INHIBIT_LAST = cnt_t'(INHIBIT_CYCLES - 1);
    localparam cnt_t SETUP_LAST   = cnt_t'(SETUP_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

    ps2_state_t state_r, state_s;
    cnt_t       cnt_r, cnt_s;
    logic [3:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] data_r, data_s;
    logic       parity_r, parity_s;
    logic       clk_oe_r, clk_oe_s;
    logic       data_oe_r, data_oe_s;
    logic       ready_r, ready_s;
    logic       done_r, done_s;
    logic       error_r, error_s;
    logic       timeout_s;

    logic       clk_level_s;
    logic       clk_fall_s;
    logic       data_level_s;
    logic       data_fall_unused_s;

    ps2_line_sync u_clk_sync (
        .clock (clock),
        .reset (reset),
        .pin   (ps2_clk_in),
        .level (clk_level_s),
        .fall  (clk_fall_s)
    );

    ps2_line_sync u_data_sync (
        .clock (clock),
        .reset (reset),
        .pin   (ps2_data_in),
        .level (data_level_s),
        .fall  (data_fall_unused_s)
    );

    // State, counters and every output are registered here
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_cnt_r <= 4'd0;
            data_r    <= 8'h00;
            parity_r  <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_cnt_r <= bit_cnt_s;
            data_r    <= data_s;
            parity_r  <= parity_s;
            clk_oe_r  <= clk_oe_s;
            data_oe_r <= data_oe_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
            error_r   <= error_s;
        end
    end

    // Next-state logic; one shared counter times inhibit, setup and the edge-gap watchdog
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_cnt_s = bit_cnt_r;
        data_s    = data_r;
        parity_s  = parity_r;
        clk_oe_s  = clk_oe_r;
        data_oe_s = data_oe_r;
        done_s    = 1'b0;
        error_s   = 1'b0;
        timeout_s = (cnt_r == TIMEOUT_LAST) && !clk_fall_s;

        case (state_r)
            IDLE: begin
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                cnt_s     = CNT_ZERO;
                bit_cnt_s = 4'd0;
                if (bus.tx_valid && ready_r) begin
                    data_s   = bus.tx_data;
                    parity_s = odd_parity(bus.tx_data);
                    clk_oe_s = 1'b1;
                    state_s  = INHIBIT;
                end else begin
                    state_s  = IDLE;
                end
            end

            INHIBIT: begin
                if (cnt_r == INHIBIT_LAST) begin
                    cnt_s     = CNT_ZERO;
                    data_oe_s = 1'b1;
                    state_s   = REQ;
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end

            REQ: begin
                if (cnt_r == SETUP_LAST) begin
                    cnt_s     = CNT_ZERO;
                    bit_cnt_s = 4'd0;
                    clk_oe_s  = 1'b0;
                    state_s   = SEND;
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end

            SEND: begin
                if (clk_fall_s) begin
                    cnt_s     = CNT_ZERO;
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    // bit_cnt_r holds k-1 for the edge being served
                    if (bit_cnt_r < 4'd8) begin
                        data_oe_s = ~data_r[bit_cnt_r[2:0]];
                    end else if (bit_cnt_r == 4'd8) begin
                        data_oe_s = ~parity_r;
                    end else begin
                        data_oe_s = 1'b0;
                        state_s   = ACK;
                    end
                end else if (timeout_s) begin
                    cnt_s     = CNT_ZERO;
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    error_s   = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end

            ACK: begin
                if (clk_fall_s) begin
                    cnt_s     = CNT_ZERO;
                    if (data_level_s) begin
                        error_s = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_IDLE;
                    end
                end else if (timeout_s) begin
                    cnt_s     = CNT_ZERO;
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    error_s   = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cnt_s     = cnt_r + CNT_ONE;
                end
            end

            WAIT_IDLE: begin
                if (clk_level_s && data_level_s) begin
                    cnt_s   = CNT_ZERO;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (clk_fall_s) begin
                    cnt_s   = CNT_ZERO;
                end else if (timeout_s) begin
                    cnt_s     = CNT_ZERO;
                    clk_oe_s  = 1'b0;
                    data_oe_s = 1'b0;
                    error_s   = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end

            default: begin
                cnt_s     = CNT_ZERO;
                clk_oe_s  = 1'b0;
                data_oe_s = 1'b0;
                state_s   = IDLE;
            end
        endcase

        ready_s = (state_s == IDLE);
    end

    assign bus.tx_ready  = ready_r;
    assign bus.tx_done   = done_r;
    assign bus.tx_error  = error_r;
    assign ps2_clk_oe    = clk_oe_r;
    assign ps2_data_oe   = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: an open-drain device model clocks frames,
// expected line bits and completion pulses are queued by the stimulus.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int SET  = 4;
    localparam int TMO  = 500;
    localparam int HALF = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    always #5 clock = ~clock;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .SETUP_CYCLES   (SET),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_accept = 0, n_pulse = 0, n_done = 0, last_pulse_cyc = 0;
    int dev_nack = 0, dev_stall = 0, dev_k = 0, dev_last_fall = 0;
    bit exp_bits[$];
    int exp_res[$];   // 1 = done, 2 = error

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance counter: sampled before the DUT's registers update on this edge
    initial forever begin
        @(posedge clock);
        if (!reset && bus.tx_valid && bus.tx_ready) n_accept++;
    end

    // Completion monitor: pops the expected outcome whenever a pulse appears
    initial begin : result_monitor
        int got;
        forever begin
            @(negedge clock);
            if (!reset && (bus.tx_done || bus.tx_error)) begin
                got = (bus.tx_done && bus.tx_error) ? 3 : (bus.tx_done ? 1 : 2);
                n_pulse++;
                if (bus.tx_done) n_done++;
                last_pulse_cyc = cyc;
                if (exp_res.size() == 0) check("unexpected_pulse", got, 0);
                else check("result_kind", got, exp_res.pop_front());
                check("ready_at_pulse", bus.tx_ready, 1);
                check("oe_at_pulse", {ps2_clk_oe, ps2_data_oe}, 0);
            end
        end
    end

    // Device model: waits for a host request, then clocks at 1/40 of the system clock
    initial begin : device
        int low;
        forever begin
            @(negedge clock);
            if (!reset && ps2_clk_oe) begin
                low = 0;
                while (ps2_clk_oe && low < 1000) begin
                    low++;
                    @(negedge clock);
                end
                check("clk_low_cycles", low, INH + SET);
                check("start_bit", ps2_data_oe, 1);
                for (int k = 1; k <= FRAME_BITS; k++) begin
                    if (dev_stall != 0 && k > dev_stall) break;
                    repeat (HALF) @(negedge clock);
                    if (k == FRAME_BITS) dev_data = (dev_nack != 0);
                    dev_clk = 1'b0;
                    dev_last_fall = cyc;
                    dev_k = k;
                    repeat (HALF) @(negedge clock);
                    if (k <= 10 && exp_bits.size() > 0)
                        check($sformatf("data_oe_k%0d", k), ps2_data_oe, exp_bits.pop_front());
                    dev_clk = 1'b1;
                end
                repeat (5) @(negedge clock);
                dev_data = 1'b1;
            end
        end
    end

    task automatic push_bits(input logic [9:0] pat, input int n);
        for (int i = 0; i < n; i++) exp_bits.push_back(pat[i]);
    endtask

    task automatic request(input logic [7:0] d);
        int a0;
        @(negedge clock);
        a0 = n_accept;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 100 && n_accept == a0; i++) @(negedge clock);
        check("accepted", n_accept - a0, 1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int p0);
        for (int i = 0; i < 3000 && n_pulse == p0; i++) @(negedge clock);
        check("pulse_seen", n_pulse - p0, 1);
        repeat (60) @(negedge clock);
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [9:0] pat, input int res);
        int p0;
        push_bits(pat, 10);
        exp_res.push_back(res);
        p0 = n_pulse;
        request(d);
        wait_pulse(p0);
    endtask

    initial begin : stimulus
        int p0, d0, a0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_ready", bus.tx_ready, 1);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_done", bus.tx_done, 0);
        check("reset_error", bus.tx_error, 0);

        // data_oe pattern bit i is the expected level at edge k=i+1
        run_frame(CMD_SET_LEDS, 10'h012, 1);
        run_frame(8'h01, 10'h1FE, 1);
        run_frame(8'h00, 10'h0FF, 1);
        run_frame(CMD_RESET, 10'h000, 1);

        // device leaves data high at the ACK edge
        dev_nack = 1;
        run_frame(8'hA5, 10'h05A, 2);
        dev_nack = 0;

        // device stops clocking after k=5: error 500 cycles after the timer clears,
        // which is 4 cycles after the pin falls
        dev_stall = 5;
        push_bits(10'h012, 5);
        exp_res.push_back(2);
        p0 = n_pulse;
        request(CMD_SET_LEDS);
        wait_pulse(p0);
        check("timeout_latency", last_pulse_cyc - dev_last_fall, TMO + 4);
        dev_stall = 0;

        // reset during SEND at k=3
        dev_stall = 3;
        dev_k = 0;
        push_bits(10'h002, 2);
        p0 = n_pulse;
        request(CMD_SET_LEDS);
        for (int i = 0; i < 2000 && dev_k != 3; i++) @(negedge clock);
        check("reached_k3", dev_k, 3);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("oe_after_reset", {ps2_clk_oe, ps2_data_oe}, 0);
        check("ready_after_reset", bus.tx_ready, 1);
        reset = 1'b0;
        repeat (80) @(negedge clock);
        check("no_pulse_after_reset", n_pulse - p0, 0);
        dev_stall = 0;
        run_frame(CMD_RESET, 10'h000, 1);

        // back-to-back: valid held high through INHIBIT and the whole first frame
        push_bits(10'h012, 10);
        push_bits(10'h1FD, 10);
        exp_res.push_back(1);
        exp_res.push_back(1);
        p0 = n_pulse;
        d0 = n_done;
        a0 = n_accept;
        @(negedge clock);
        bus.tx_data  = CMD_SET_LEDS;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 100 && n_accept == a0; i++) @(negedge clock);
        bus.tx_data = 8'h02;
        check("ready_low_after_accept", bus.tx_ready, 0);
        repeat (5) @(negedge clock);
        check("ignored_during_inhibit", n_accept - a0, 1);
        for (int i = 0; i < 3000 && n_accept < a0 + 2; i++) @(negedge clock);
        check("second_accept", n_accept - a0, 2);
        check("first_done_before_second", n_done - d0, 1);
        bus.tx_valid = 1'b0;
        wait_pulse(p0 + 1);
        check("back_to_back_dones", n_done - d0, 2);

        check("bits_left", exp_bits.size(), 0);
        check("results_left", exp_res.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
